// File: rtl/key_event_unit.sv
// key_event_unit: per-channel synchroniser, debouncer and event classifier for
// active-low push buttons (press, release, long press, auto-repeat, double click).
module key_event_unit #(
   parameter int CHANNELS = 4,
   parameter int DEB_CYC  = 500_000,
   parameter int HOLD_CYC = 50_000_000,
   parameter int REP_CYC  = 5_000_000,
   parameter int DCLK_CYC = 15_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   key_n,
   input  logic                  en,
   output logic [CHANNELS-1:0]   held,
   output logic [CHANNELS-1:0]   press,
   output logic [CHANNELS-1:0]   key_release,
   output logic [CHANNELS-1:0]   long_press,
   output logic [CHANNELS-1:0]   auto_repeat,
   output logic [CHANNELS-1:0]   dclick,
   output logic [2*CHANNELS-1:0] fsm_state
);

   // "release" and "repeat" are reserved words, hence key_release / auto_repeat.
   localparam int DEB_W  = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
   localparam int HOLD_W = $clog2(HOLD_CYC);
   localparam int REP_W  = (REP_CYC  > 1) ? $clog2(REP_CYC)  : 1;
   localparam int DCLK_W = (DCLK_CYC > 1) ? $clog2(DCLK_CYC) : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);
   localparam logic [DCLK_W-1:0] DCLK_LAST = DCLK_W'(DCLK_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DOWN   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic              sync1_q, sync1_d, sync2_q, sync2_d;
      logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
      logic              held_q, held_d, held_prev_q, held_prev_d;
      state_t            state_q, state_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
      logic [DCLK_W-1:0] win_cnt_q, win_cnt_d;
      logic              suppress_q, suppress_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              long_q, long_d;
      logic              repeat_q, repeat_d;
      logic              dclick_q, dclick_d;
      logic              rise, fall;

      // Debounce: held flips only after DEB_CYC consecutive mismatching edges.
      always_comb begin
         sync1_d     = ~key_n[ch];
         sync2_d     = sync1_q;
         held_d      = held_q;
         deb_cnt_d   = '0;
         held_prev_d = held_q;
         if (sync2_q != held_q) begin
            if (deb_cnt_q == DEB_LAST) begin
               held_d = ~held_q;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
      end

      assign rise = held_q & ~held_prev_q;
      assign fall = ~held_q & held_prev_q;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q <= ST_IDLE;
         end else begin
            state_q <= state_d;
         end
      end

      always_comb begin
         state_d = state_q;
         if (!en) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE:   if (rise) state_d = ST_DOWN;
               ST_DOWN: begin
                  if (fall)                          state_d = suppress_q ? ST_IDLE : ST_GAP;
                  else if (hold_cnt_q == HOLD_LAST)  state_d = ST_REPEAT;
               end
               ST_REPEAT: if (fall) state_d = ST_IDLE;
               ST_GAP: begin
                  if (rise)                          state_d = ST_DOWN;
                  else if (win_cnt_q == DCLK_LAST)   state_d = ST_IDLE;
               end
               default:   state_d = ST_IDLE;
            endcase
         end
      end

      // Counters restart from zero on every state entry because they default to 0.
      always_comb begin
         press_d    = 1'b0;
         release_d  = 1'b0;
         long_d     = 1'b0;
         repeat_d   = 1'b0;
         dclick_d   = 1'b0;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
         win_cnt_d  = '0;
         suppress_d = suppress_q;
         if (!en) begin
            suppress_d = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: press_d = rise;
               ST_DOWN: begin
                  if (fall) begin
                     release_d  = 1'b1;
                     suppress_d = 1'b0;
                  end else if (hold_cnt_q == HOLD_LAST) begin
                     long_d = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (fall) begin
                     release_d  = 1'b1;
                     suppress_d = 1'b0;
                  end else if (rep_cnt_q == REP_LAST) begin
                     repeat_d = 1'b1;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
               ST_GAP: begin
                  if (rise) begin
                     press_d    = 1'b1;
                     dclick_d   = 1'b1;
                     suppress_d = 1'b1;
                  end else if (win_cnt_q != DCLK_LAST) begin
                     win_cnt_d = win_cnt_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            held_q      <= 1'b0;
            held_prev_q <= 1'b0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            win_cnt_q   <= '0;
            suppress_q  <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            dclick_q    <= 1'b0;
         end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            held_q      <= held_d;
            held_prev_q <= held_prev_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            win_cnt_q   <= win_cnt_d;
            suppress_q  <= suppress_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            dclick_q    <= dclick_d;
         end
      end

      assign held[ch]             = held_q;
      assign press[ch]            = press_q;
      assign key_release[ch]      = release_q;
      assign long_press[ch]       = long_q;
      assign auto_repeat[ch]      = repeat_q;
      assign dclick[ch]           = dclick_q;
      assign fsm_state[2*ch +: 2] = state_q;
   end

endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: scenario bench for key_event_unit; a timestamp-based
// behavioural model fills an expected queue that each scenario drains.
`timescale 1ns/1ps
module tb_key_event_unit;

   localparam int CH   = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int REP  = 5;
   localparam int DCLK = 10;
   localparam int MAXN = 400;
   localparam int W    = 6 * CH;

   localparam int PH_IDLE = 0;
   localparam int PH_DOWN = 1;
   localparam int PH_LONG = 2;
   localparam int PH_GAP  = 3;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [CH-1:0]   key_n = '1;
   logic            en    = 1'b1;
   logic [CH-1:0]   held, press, key_release, long_press, auto_repeat, dclick;
   logic [2*CH-1:0] fsm_state;

   int checks   = 0;
   int failures = 0;

   logic [CH-1:0] key_arr [MAXN];
   logic          en_arr  [MAXN];
   logic [CH-1:0] o_held [MAXN];
   logic [CH-1:0] o_press[MAXN];
   logic [CH-1:0] o_rel  [MAXN];
   logic [CH-1:0] o_long [MAXN];
   logic [CH-1:0] o_rep  [MAXN];
   logic [CH-1:0] o_dcl  [MAXN];
   logic [W-1:0]  exp_q[$];

   key_event_unit #(
      .CHANNELS(CH), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP), .DCLK_CYC(DCLK)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .en(en),
      .held(held), .press(press), .key_release(key_release),
      .long_press(long_press), .auto_repeat(auto_repeat), .dclick(dclick),
      .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset(input logic [CH-1:0] kv);
      @(negedge clk);
      reset = 1'b0;
      key_n = kv;
      en    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_stim();
      for (int j = 0; j < MAXN; j++) begin
         key_arr[j] = '1;
         en_arr[j]  = 1'b1;
      end
   endtask

   task automatic set_key(input int c, input int lo, input int hi);
      for (int j = lo; j < hi && j < MAXN; j++) key_arr[j][c] = 1'b0;
   endtask

   // Entry index j is the j-th edge after reset deasserts.
   task automatic run_capture(input int n);
      for (int j = 0; j < n; j++) begin
         key_n = key_arr[j];
         en    = en_arr[j];
         @(posedge clk);
         #1;
         o_held[j]  = held;
         o_press[j] = press;
         o_rel[j]   = key_release;
         o_long[j]  = long_press;
         o_rep[j]   = auto_repeat;
         o_dcl[j]   = dclick;
         @(negedge clk);
      end
   endtask

   function automatic logic [W-1:0] obs_vec(input int j);
      return {o_held[j], o_press[j], o_rel[j], o_long[j], o_rep[j], o_dcl[j]};
   endfunction

   // ---------------- reference model ----------------
   task automatic build_expected(input int n);
      logic [CH-1:0] hm  [MAXN];
      logic [CH-1:0] e_p [MAXN];
      logic [CH-1:0] e_r [MAXN];
      logic [CH-1:0] e_l [MAXN];
      logic [CH-1:0] e_rp[MAXN];
      logic [CH-1:0] e_d [MAXN];
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         hm[k] = '0; e_p[k] = '0; e_r[k] = '0; e_l[k] = '0; e_rp[k] = '0; e_d[k] = '0;
      end
      for (int c = 0; c < CH; c++) begin
         int   run, phase, t_p, t_r;
         bit   dcl;
         logic s2_pre, h1, h2, rise, fall;
         run = 0; phase = PH_IDLE; t_p = 0; t_r = 0; dcl = 1'b0;
         for (int k = 0; k < n; k++) begin
            // Two-flop synchroniser: the value visible before edge k was sampled at edge k-2.
            s2_pre = (k >= 2) ? ~key_arr[k-2][c] : 1'b0;
            h1     = (k >= 1) ? hm[k-1][c] : 1'b0;
            h2     = (k >= 2) ? hm[k-2][c] : 1'b0;
            run    = (s2_pre != h1) ? run + 1 : 0;
            hm[k][c] = h1;
            if (run == DEB) begin
               hm[k][c] = ~h1;
               run = 0;
            end
            rise = h1 & ~h2;
            fall = ~h1 & h2;
            if (!en_arr[k]) begin
               phase = PH_IDLE;
               dcl   = 1'b0;
            end else begin
               case (phase)
                  PH_IDLE: if (rise) begin
                     e_p[k][c] = 1'b1; t_p = k; phase = PH_DOWN;
                  end
                  PH_DOWN: begin
                     if (fall) begin
                        e_r[k][c] = 1'b1;
                        if (dcl) begin phase = PH_IDLE; dcl = 1'b0; end
                        else begin phase = PH_GAP; t_r = k; end
                     end else if (k - t_p == HOLD) begin
                        e_l[k][c] = 1'b1; phase = PH_LONG;
                     end
                  end
                  PH_LONG: begin
                     if (fall) begin
                        e_r[k][c] = 1'b1; phase = PH_IDLE; dcl = 1'b0;
                     end else if ((k - t_p - HOLD) % REP == 0) begin
                        e_rp[k][c] = 1'b1;
                     end
                  end
                  default: begin
                     if (rise) begin
                        e_p[k][c] = 1'b1; e_d[k][c] = 1'b1; t_p = k; phase = PH_DOWN; dcl = 1'b1;
                     end else if (k - t_r >= DCLK) begin
                        phase = PH_IDLE;
                     end
                  end
               endcase
            end
         end
      end
      for (int k = 0; k < n; k++) exp_q.push_back({hm[k], e_p[k], e_r[k], e_l[k], e_rp[k], e_d[k]});
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int g, n;
      logic any_held;
      logic [W-1:0] exp_v;
      @(negedge clk);
      reset = 1'b0; key_n = '1; en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({held, press, key_release, long_press, auto_repeat, dclick, fsm_state} !== '0) begin
         failures++;
         $display("FAIL reset_initial got=%h exp=0", {held, press, key_release, long_press, auto_repeat, dclick, fsm_state});
      end
      @(negedge clk);
      reset = 1'b1;
      clear_stim();
      set_key(0, 0, 15);
      run_capture(15);
      reset = 1'b0; key_n = '1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({held, press, key_release, long_press, auto_repeat, dclick, fsm_state} !== '0) begin
            failures++;
            $display("FAIL reset_midactive edge=%0d got=%h exp=0", i, {held, press, key_release, long_press, auto_repeat, dclick, fsm_state});
         end
      end
      @(negedge clk);
      reset = 1'b1;
      n = 20;
      g = $urandom_range(2, 6);
      clear_stim();
      set_key(0, g, g + 3);
      run_capture(n);
      build_expected(n);
      any_held = 1'b0;
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         any_held = any_held | (|o_held[j]) | (|o_press[j]);
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL glitch_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if (any_held !== 1'b0) begin
         failures++;
         $display("FAIL glitch_ignored got=%b exp=0", any_held);
      end
   endtask

   task automatic test_press_latency();
      int n;
      logic [W-1:0] exp_v;
      n = 30;
      do_reset('1);
      clear_stim();
      set_key(0, 0, 12);
      run_capture(n);
      build_expected(n);
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL latency_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if ({o_held[4][0], o_held[5][0]} !== 2'b01) begin
         failures++;
         $display("FAIL held_rise got=%b exp=01", {o_held[4][0], o_held[5][0]});
      end
      checks++;
      if ({o_press[5][0], o_press[6][0], o_press[7][0]} !== 3'b010) begin
         failures++;
         $display("FAIL press_pulse got=%b exp=010", {o_press[5][0], o_press[6][0], o_press[7][0]});
      end
      checks++;
      if ({o_held[16][0], o_held[17][0], o_rel[17][0], o_rel[18][0], o_rel[19][0]} !== 5'b10010) begin
         failures++;
         $display("FAIL release_pulse got=%b exp=10010",
                  {o_held[16][0], o_held[17][0], o_rel[17][0], o_rel[18][0], o_rel[19][0]});
      end
   endtask

   task automatic test_long_repeat();
      int n, extra, n_rel, n_dcl, n_long;
      logic [W-1:0] exp_v;
      n = 80;
      extra = $urandom_range(0, 3);
      do_reset('1);
      clear_stim();
      set_key(0, 0, 51 + extra);
      run_capture(n);
      build_expected(n);
      n_rel = 0; n_dcl = 0; n_long = 0;
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         n_rel  += int'(o_rel[j][0]);
         n_dcl  += int'(o_dcl[j][0]);
         n_long += int'(o_long[j][0]);
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL long_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if (o_long[26][0] !== 1'b1 || n_long != 1) begin
         failures++;
         $display("FAIL long_press_at_t20 got=%b count=%0d exp=1 count=1", o_long[26][0], n_long);
      end
      checks++;
      if ({o_rep[31][0], o_rep[36][0], o_rep[41][0], o_rep[46][0], o_rep[30][0]} !== 5'b11110) begin
         failures++;
         $display("FAIL repeat_times got=%b exp=11110",
                  {o_rep[31][0], o_rep[36][0], o_rep[41][0], o_rep[46][0], o_rep[30][0]});
      end
      checks++;
      if (n_rel != 1 || n_dcl != 0) begin
         failures++;
         $display("FAIL long_release_count got rel=%0d dcl=%0d exp rel=1 dcl=0", n_rel, n_dcl);
      end
   endtask

   task automatic test_double_click();
      int n, n_dcl, n_prs, l1, g1, l2, g2, l3, s;
      logic [W-1:0] exp_v;
      n = 80;
      for (int v = 0; v < 3; v++) begin
         do_reset('1);
         clear_stim();
         if (v == 0) begin
            set_key(0, 0, 8); set_key(0, 18, 26);
         end else if (v == 1) begin
            set_key(0, 0, 8); set_key(0, 19, 27);
         end else begin
            l1 = $urandom_range(5, 9); g1 = $urandom_range(5, 9);
            l2 = $urandom_range(5, 9); g2 = $urandom_range(5, 9);
            l3 = $urandom_range(5, 9);
            s = 0;
            set_key(0, s, s + l1); s += l1 + g1;
            set_key(0, s, s + l2); s += l2 + g2;
            set_key(0, s, s + l3);
         end
         run_capture(n);
         build_expected(n);
         n_dcl = 0; n_prs = 0;
         for (int j = 0; j < n; j++) begin
            exp_v = exp_q.pop_front();
            n_dcl += int'(o_dcl[j][0]);
            n_prs += int'(o_press[j][0]);
            checks++;
            if (obs_vec(j) !== exp_v) begin
               failures++;
               $display("FAIL dclick_trace v=%0d cyc=%0d got=%h exp=%h", v, j, obs_vec(j), exp_v);
            end
         end
         if (v == 0) begin
            checks++;
            if ({o_rel[14][0], o_press[24][0], o_dcl[24][0]} !== 3'b111 || n_dcl != 1) begin
               failures++;
               $display("FAIL dclick_at_r10 got=%b count=%0d exp=111 count=1",
                        {o_rel[14][0], o_press[24][0], o_dcl[24][0]}, n_dcl);
            end
         end else if (v == 1) begin
            checks++;
            if (o_press[25][0] !== 1'b1 || n_dcl != 0) begin
               failures++;
               $display("FAIL no_dclick_at_r11 got press=%b count=%0d exp press=1 count=0", o_press[25][0], n_dcl);
            end
         end else begin
            checks++;
            if (n_dcl != 1 || n_prs != 3) begin
               failures++;
               $display("FAIL triple_click got dcl=%0d prs=%0d exp dcl=1 prs=3", n_dcl, n_prs);
            end
         end
      end
   endtask

   task automatic test_enable();
      int n, n_ev;
      logic held_ok;
      logic [W-1:0] exp_v;
      n = 60;
      do_reset('1);
      clear_stim();
      set_key(0, 0, n);
      for (int j = 16; j < 21; j++) en_arr[j] = 1'b0;
      run_capture(n);
      build_expected(n);
      n_ev = 0; held_ok = 1'b1;
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         if (j >= 7) n_ev += int'(o_press[j][0]) + int'(o_long[j][0]) + int'(o_rep[j][0]);
         if (j >= 5 && o_held[j][0] !== 1'b1) held_ok = 1'b0;
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL enable_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if (n_ev != 0 || held_ok !== 1'b1) begin
         failures++;
         $display("FAIL enable_suppress got events=%0d held_ok=%b exp events=0 held_ok=1", n_ev, held_ok);
      end
   endtask

   task automatic test_channel_indep();
      int n, h0, h1;
      logic [W-1:0] exp_v;
      n = 80;
      h0 = $urandom_range(25, 40);
      h1 = $urandom_range(25, 40);
      do_reset('1);
      clear_stim();
      set_key(0, 0, h0);
      set_key(1, 3, 3 + h1);
      run_capture(n);
      build_expected(n);
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL indep_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if ({o_press[6], o_press[9], o_long[26], o_long[29]} !== 8'b01_10_01_10) begin
         failures++;
         $display("FAIL indep_times got=%b exp=01100110", {o_press[6], o_press[9], o_long[26], o_long[29]});
      end
   endtask

   task automatic test_reset_midop();
      int n;
      logic [W-1:0] exp_v;
      n = 40;
      do_reset('1);
      clear_stim();
      set_key(0, 0, 20);
      run_capture(12);
      do_reset(2'b10);
      clear_stim();
      set_key(0, 0, 30);
      run_capture(n);
      build_expected(n);
      for (int j = 0; j < n; j++) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs_vec(j) !== exp_v) begin
            failures++;
            $display("FAIL midop_trace cyc=%0d got=%h exp=%h", j, obs_vec(j), exp_v);
         end
      end
      checks++;
      if ({o_press[5][0], o_press[6][0]} !== 2'b01) begin
         failures++;
         $display("FAIL midop_fresh_press got=%b exp=01", {o_press[5][0], o_press[6][0]});
      end
   endtask

   task automatic test_random();
      int n, j, len;
      logic lvl;
      logic [W-1:0] exp_v;
      n = 300;
      for (int it = 0; it < 4; it++) begin
         do_reset('1);
         clear_stim();
         for (int c = 0; c < CH; c++) begin
            j = 0; lvl = 1'b1;
            while (j < n) begin
               len = $urandom_range(1, 35);
               for (int k = j; k < j + len && k < n; k++) key_arr[k][c] = lvl;
               j += len;
               lvl = ~lvl;
            end
         end
         j = 0;
         while (j < n) begin
            if ($urandom_range(0, 39) == 0) begin
               len = $urandom_range(2, 8);
               for (int k = j; k < j + len && k < n; k++) en_arr[k] = 1'b0;
               j += len;
            end else begin
               j++;
            end
         end
         run_capture(n);
         build_expected(n);
         for (int k = 0; k < n; k++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_vec(k) !== exp_v) begin
               failures++;
               $display("FAIL random_trace it=%0d cyc=%0d got=%h exp=%h", it, k, obs_vec(k), exp_v);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_press_latency();
      test_long_repeat();
      test_double_click();
      test_enable();
      test_channel_indep();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
